// File: rtl/pll_reset_sequencer_if.sv
// Lock input and reset/status outputs of pll_reset_sequencer bundled as one port.
// slave = sequencer side, master = PLL/core environment side.
interface pll_reset_sequencer_if #(
  parameter int unsigned LOSS_CNT_W = 8
);
  logic                  PLL_LOCK;
  logic                  RST_N_OUT;
  logic                  READY;
  logic                  READY_PULSE;
  logic [1:0]            STATE;
  logic [LOSS_CNT_W-1:0] LOSS_COUNT;

  modport master (
    output PLL_LOCK,
    input  RST_N_OUT,
    input  READY,
    input  READY_PULSE,
    input  STATE,
    input  LOSS_COUNT
  );

  modport slave (
    input  PLL_LOCK,
    output RST_N_OUT,
    output READY,
    output READY_PULSE,
    output STATE,
    output LOSS_COUNT
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies a synchronised PLL lock, holds core reset, then releases RST_N_OUT/READY.
// Optional lock-loss counter enabled by defining PLL_RSTSEQ_LOSS_CNT_EN.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 4096,
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned LOSS_CNT_W         = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  pll_reset_sequencer_if.slave  bus
);

  localparam int unsigned MAX_CYC = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                    LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic                   rst_n_q;
  logic                   ready_q;
  logic                   pulse_q;

  // PLL_LOCK is asynchronous to CLK; only the last stage is ever consumed.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.PLL_LOCK};
    end
  end

  assign lock_s = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Lock loss is tested before terminal count so a drop on the last cycle wins.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Outputs registered from next-state so they move on the same edge as state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rst_n_q <= 1'b0;
      ready_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      rst_n_q <= (state_nxt == RUN);
      ready_q <= (state_nxt == RUN);
      pulse_q <= (state_nxt == RUN) && (state != RUN);
    end
  end

  assign bus.RST_N_OUT   = rst_n_q;
  assign bus.READY       = ready_q;
  assign bus.READY_PULSE = pulse_q;
  assign bus.STATE       = state;

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;
  logic                  lost_in_run;

  assign lost_in_run = (state == RUN) && !lock_s;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      loss_cnt <= '0;
    end else if (lost_in_run && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  assign bus.LOSS_COUNT = loss_cnt;
`else
  assign bus.LOSS_COUNT = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expected outputs queued per edge, popped and checked 1 ns later.
module tb_pll_reset_sequencer;
  localparam int unsigned LW = 2;

  logic CLK = 1'b0;
  logic RESET;

  pll_reset_sequencer_if #(.LOSS_CNT_W(LW)) bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .RST_HOLD_CYCLES   (4),
    .LOSS_CNT_W        (LW)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          edge_no;
    logic [1:0]  st;
    logic        rstn;
    logic        rdy;
    logic        pulse;
    logic [LW-1:0] loss;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  string         phase  = "init";
  logic [LW-1:0] loss_model = '0;

  task automatic cmp(input string name, input int edge_no, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s %s edge %0d: got %0h expected %0h", phase, name, edge_no, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int edge_no, input logic [1:0] st, input logic pulse);
    exp_t e;
    e.edge_no = edge_no;
    e.st      = st;
    e.rstn    = (st == 2'd3);
    e.rdy     = (st == 2'd3);
    e.pulse   = pulse;
    e.loss    = loss_model;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard: got empty queue expected entry", phase);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp("STATE",       e.edge_no, 8'(bus.STATE),       8'(e.st));
      cmp("RST_N_OUT",   e.edge_no, 8'(bus.RST_N_OUT),   8'(e.rstn));
      cmp("READY",       e.edge_no, 8'(bus.READY),       8'(e.rdy));
      cmp("READY_PULSE", e.edge_no, 8'(bus.READY_PULSE), 8'(e.pulse));
      cmp("LOSS_COUNT",  e.edge_no, 8'(bus.LOSS_COUNT),  8'(e.loss));
    end
  endtask

  task automatic tick_check(input int edge_no, input logic [1:0] st, input logic pulse);
    push_exp(edge_no, st, pulse);
    @(posedge CLK);
    #1;
    pop_check();
  endtask

  // r = edge on which lock_s becomes 1; state changes one edge later.
  function automatic logic [1:0] exp_state(input int k, input int r);
    if (k <= r)           return 2'd0;
    else if (k <= r + 8)  return 2'd1;
    else if (k <= r + 12) return 2'd2;
    else                  return 2'd3;
  endfunction

  task automatic track(input int first, input int last, input int r);
    for (int k = first; k <= last; k++) begin
      tick_check(k, exp_state(k, r), (k == r + 13));
    end
  endtask

  task automatic loss_bump();
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    if (loss_model != '1) loss_model = loss_model + 1'b1;
`endif
  endtask

  // From RUN: lock low, two edges to reach lock_s, one more to leave RUN; lock back high.
  task automatic drop_from_run();
    bus.PLL_LOCK = 1'b0;
    tick_check(-3, 2'd3, 1'b0);
    tick_check(-2, 2'd3, 1'b0);
    loss_bump();
    tick_check(-1, 2'd0, 1'b0);
    bus.PLL_LOCK = 1'b1;
  endtask

  initial begin
    RESET        = 1'b1;
    bus.PLL_LOCK = 1'b1;
    #2;
    RESET = 1'b0;

    phase = "power_up";
    #1;
    push_exp(-99, 2'd0, 1'b0);
    pop_check();
    for (int i = 0; i < 5; i++) tick_check(-10 + i, 2'd0, 1'b0);

    phase = "clean_lock";
    RESET = 1'b1;
    track(0, 15, 1);

    for (int n = 0; n < 4; n++) begin
      phase = $sformatf("run_loss_%0d", n);
      drop_from_run();
      track(0, 15, 1);
    end

    phase = "stable_glitch";
    drop_from_run();
    track(0, 4, 1);
    bus.PLL_LOCK = 1'b0;
    tick_check(5, 2'd1, 1'b0);
    bus.PLL_LOCK = 1'b1;
    tick_check(6, 2'd1, 1'b0);
    tick_check(7, 2'd0, 1'b0);
    track(8, 21, 7);

    phase = "terminal_drop";
    drop_from_run();
    track(0, 7, 1);
    bus.PLL_LOCK = 1'b0;
    tick_check(8, 2'd1, 1'b0);
    bus.PLL_LOCK = 1'b1;
    tick_check(9, 2'd1, 1'b0);
    tick_check(10, 2'd0, 1'b0);
    track(11, 24, 10);

    phase = "async_reset";
    #3;
    RESET = 1'b0;
    loss_model = '0;
    #1;
    push_exp(-99, 2'd0, 1'b0);
    pop_check();
    tick_check(-2, 2'd0, 1'b0);
    tick_check(-1, 2'd0, 1'b0);
    RESET = 1'b1;
    phase = "after_reset";
    track(0, 15, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
